// File: rtl/usb_fifo_host_if_if.sv
// usb_fifo_host_if_if: command, USB slave-FIFO and sample-stream signals of the host link.
interface usb_fifo_host_if_if;
  logic        host_cmd_valid;
  logic [15:0] host_cmd_data;
  logic        host_cmd_ready;
  logic        usb_read_clk;
  logic [15:0] usb_read_data;
  logic        usb_read_wait;
  logic        usb_read_en;
  logic        usb_write_clk;
  logic [15:0] usb_write_data;
  logic        usb_write_en;
  logic        usb_write_wait;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic [9:0]  rx_index;
  logic        rx_last;
  logic        rx_ready;
  logic        frame_active;
  logic        frame_done;
  logic        overflow_err;
  logic        underflow_err;
  logic        proto_err;
  logic        clear_err;
  modport slave (
    input  host_cmd_valid, host_cmd_data, usb_read_en, usb_write_data, usb_write_en, rx_ready, clear_err,
    output host_cmd_ready, usb_read_clk, usb_read_data, usb_read_wait, usb_write_clk, usb_write_wait,
           rx_valid, rx_data, rx_index, rx_last, frame_active, frame_done, overflow_err, underflow_err, proto_err
  );
  modport master (
    output host_cmd_valid, host_cmd_data, usb_read_en, usb_write_data, usb_write_en, rx_ready, clear_err,
    input  host_cmd_ready, usb_read_clk, usb_read_data, usb_read_wait, usb_write_clk, usb_write_wait,
           rx_valid, rx_data, rx_index, rx_last, frame_active, frame_done, overflow_err, underflow_err, proto_err
  );
endinterface

// File: rtl/usb_fifo_host_if.sv
// usb_fifo_host_if: peripheral side of the USB slave-FIFO link; buffers commands, frames and pairs sample words.
module usb_fifo_host_if #(
  parameter int          CMD_DEPTH   = 8,
  parameter int          RX_DEPTH    = 16,
  parameter int          FRAME_WORDS = 1024,
  parameter logic [15:0] CMD_FETCH   = 16'hFFFF
) (
  input logic clk,
  input logic rst_n,
  usb_fifo_host_if_if.slave bus
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [9:0] LAST = 10'(FRAME_WORDS - 1);
  typedef enum logic [1:0] {S_IDLE, S_LSW, S_MSW} state_t;
  state_t state, state_nx;
  logic [15:0] cmd_mem [CMD_DEPTH];
  logic [CAW:0] cmd_wp, cmd_rp;
  logic [41:0] rx_mem [RX_DEPTH];
  logic [RAW:0] rx_wp, rx_rp;
  logic [15:0] lsw_reg, cmd_head;
  logic [41:0] rx_head;
  logic [9:0] count;
  logic cmd_empty, cmd_full, cmd_push, cmd_pop, fetch;
  logic rx_empty, rx_full, rx_pop;
  logic active, wr_acc, lsw_load, rx_push;
  logic frame_done_q, overflow_q, underflow_q, proto_q;
  assign cmd_empty = cmd_wp == cmd_rp;
  assign cmd_full  = (cmd_wp ^ cmd_rp) == {1'b1, {CAW{1'b0}}};
  assign cmd_push  = bus.host_cmd_valid & ~cmd_full;
  assign cmd_pop   = bus.usb_read_en & ~cmd_empty;
  assign cmd_head  = cmd_mem[cmd_rp[CAW-1:0]];
  assign fetch     = cmd_pop & (cmd_head == CMD_FETCH);
  assign rx_empty  = rx_wp == rx_rp;
  assign rx_full   = (rx_wp ^ rx_rp) == {1'b1, {RAW{1'b0}}};
  assign rx_pop    = bus.rx_ready & ~rx_empty;
  assign rx_head   = rx_mem[rx_rp[RAW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (fetch) state_nx = S_LSW;
    else if (wr_acc) state_nx = (state == S_LSW) ? S_MSW : ((count == LAST) ? S_IDLE : S_LSW);
  end
  // A fetch popped on the same edge as a write restarts the frame and the word is not paired.
  always_comb begin
    active   = state != S_IDLE;
    wr_acc   = bus.usb_write_en & active & ~rx_full;
    lsw_load = wr_acc & ~fetch & (state == S_LSW);
    rx_push  = wr_acc & ~fetch & (state == S_MSW);
  end
  always_ff @(posedge clk)
    if (cmd_push) cmd_mem[cmd_wp[CAW-1:0]] <= bus.host_cmd_data;
  always_ff @(posedge clk)
    if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= {count, bus.usb_write_data, lsw_reg};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd_wp       <= '0;
      cmd_rp       <= '0;
      rx_wp        <= '0;
      rx_rp        <= '0;
      lsw_reg      <= '0;
      count        <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      proto_q      <= 1'b0;
    end else begin
      cmd_wp       <= cmd_wp + (CAW+1)'(cmd_push);
      cmd_rp       <= cmd_rp + (CAW+1)'(cmd_pop);
      rx_wp        <= rx_wp + (RAW+1)'(rx_push);
      rx_rp        <= rx_rp + (RAW+1)'(rx_pop);
      lsw_reg      <= lsw_load ? bus.usb_write_data : lsw_reg;
      count        <= fetch ? '0 : count + 10'(rx_push);
      frame_done_q <= rx_push & (count == LAST);
      overflow_q   <= ~bus.clear_err & (overflow_q | (bus.usb_write_en & rx_full));
      underflow_q  <= ~bus.clear_err & (underflow_q | (bus.usb_read_en & cmd_empty));
      proto_q      <= ~bus.clear_err & (proto_q | (bus.usb_write_en & ~active));
    end
  assign bus.host_cmd_ready = ~cmd_full;
  assign bus.usb_read_clk   = clk;
  assign bus.usb_read_data  = cmd_empty ? 16'h0 : cmd_head;
  assign bus.usb_read_wait  = cmd_empty;
  assign bus.usb_write_clk  = clk;
  assign bus.usb_write_wait = rx_full;
  assign bus.rx_valid       = ~rx_empty;
  assign bus.rx_data        = rx_empty ? 32'h0 : rx_head[31:0];
  assign bus.rx_index       = rx_empty ? 10'h0 : rx_head[41:32];
  assign bus.rx_last        = ~rx_empty & (rx_head[41:32] == LAST);
  assign bus.frame_active   = active;
  assign bus.frame_done     = frame_done_q;
  assign bus.overflow_err   = overflow_q;
  assign bus.underflow_err  = underflow_q;
  assign bus.proto_err      = proto_q;
endmodule

// File: tb/tb_usb_fifo_host_if.sv
// tb_usb_fifo_host_if: directed checks of command buffering, frame pairing, flow control and errors.
module tb_usb_fifo_host_if;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  usb_fifo_host_if_if bus ();
  usb_fifo_host_if dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [41:0] got, input logic [41:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push_cmd(input logic [15:0] d);
    bus.host_cmd_valid = 1'b1;
    bus.host_cmd_data  = d;
    tick();
    bus.host_cmd_valid = 1'b0;
  endtask
  task automatic read_pulse();
    bus.usb_read_en = 1'b1;
    tick();
    bus.usb_read_en = 1'b0;
  endtask
  task automatic wr(input logic [15:0] d);
    bus.usb_write_en   = 1'b1;
    bus.usb_write_data = d;
    tick();
    bus.usb_write_en   = 1'b0;
  endtask
  initial begin
    bus.host_cmd_valid = 1'b0;
    bus.host_cmd_data  = '0;
    bus.usb_read_en    = 1'b0;
    bus.usb_write_data = '0;
    bus.usb_write_en   = 1'b0;
    bus.rx_ready       = 1'b0;
    bus.clear_err      = 1'b0;
    tick();
    tick();
    chk("rst_read_wait", 42'(bus.usb_read_wait), 42'd1);
    chk("rst_read_data", 42'(bus.usb_read_data), 42'd0);
    chk("rst_write_wait", 42'(bus.usb_write_wait), 42'd0);
    chk("rst_cmd_ready", 42'(bus.host_cmd_ready), 42'd1);
    chk("rst_rx_valid", 42'(bus.rx_valid), 42'd0);
    chk("rst_errs", 42'({bus.overflow_err, bus.underflow_err, bus.proto_err}), 42'd0);
    rst_n = 1'b1;
    tick();
    push_cmd(16'hFFFF);
    chk("cmd_head", 42'(bus.usb_read_data), 42'hFFFF);
    chk("cmd_wait0", 42'(bus.usb_read_wait), 42'd0);
    read_pulse();
    chk("cmd_wait1", 42'(bus.usb_read_wait), 42'd1);
    chk("fetch_active", 42'(bus.frame_active), 42'd1);
    wr(16'h0003);
    chk("lsw_no_push", 42'(bus.rx_valid), 42'd0);
    wr(16'h0000);
    chk("s0_valid", 42'(bus.rx_valid), 42'd1);
    chk("s0_data", 42'(bus.rx_data), 42'h00000003);
    chk("s0_index", 42'(bus.rx_index), 42'd0);
    wr(16'h0004);
    wr(16'h0001);
    chk("s0_still_head", 42'(bus.rx_data), 42'h00000003);
    bus.rx_ready = 1'b1;
    tick();
    chk("s1_data", 42'(bus.rx_data), 42'h00010004);
    chk("s1_index", 42'(bus.rx_index), 42'd1);
    tick();
    bus.rx_ready = 1'b0;
    chk("drained", 42'(bus.rx_valid), 42'd0);
    for (int i = 0; i < 16; i++) begin
      wr(16'(i));
      wr(16'h00AA);
      if (i == 14) chk("wait_at15", 42'(bus.usb_write_wait), 42'd0);
    end
    chk("wait_full", 42'(bus.usb_write_wait), 42'd1);
    chk("full_head", 42'({bus.rx_index, bus.rx_data}), {10'd2, 32'h00AA0000});
    wr(16'hBEEF);
    chk("ovf_err", 42'(bus.overflow_err), 42'd1);
    chk("ovf_head", 42'({bus.rx_index, bus.rx_data}), {10'd2, 32'h00AA0000});
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    chk("wait_freed", 42'(bus.usb_write_wait), 42'd0);
    chk("head_after_pop", 42'({bus.rx_index, bus.rx_data}), {10'd3, 32'h00AA0001});
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("last_queued", 42'({bus.rx_index, bus.rx_data}), {10'd17, 32'h00AA000F});
    tick();
    chk("drained2", 42'(bus.rx_valid), 42'd0);
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    chk("ovf_cleared", 42'(bus.overflow_err), 42'd0);
    push_cmd(16'hFFFF);
    read_pulse();
    for (int i = 0; i < 1024; i++) begin
      wr(16'(i));
      wr(16'hC000 | 16'(i));
      chk("frame_sample", 42'({bus.rx_index, bus.rx_data}), {10'(i), 16'hC000 | 16'(i), 16'(i)});
      chk("frame_last", 42'(bus.rx_last), 42'(i == 1023));
      chk("frame_done_pulse", 42'(bus.frame_done), 42'(i == 1023));
    end
    chk("frame_closed", 42'(bus.frame_active), 42'd0);
    wr(16'h1111);
    chk("done_one_cycle", 42'(bus.frame_done), 42'd0);
    chk("proto_err", 42'(bus.proto_err), 42'd1);
    chk("proto_no_push", 42'(bus.rx_valid), 42'd0);
    bus.clear_err = 1'b1;
    wr(16'h2222);
    bus.clear_err = 1'b0;
    chk("clear_wins", 42'(bus.proto_err), 42'd0);
    read_pulse();
    chk("underflow_err", 42'(bus.underflow_err), 42'd1);
    push_cmd(16'hFFFF);
    read_pulse();
    wr(16'h1234);
    for (int i = 0; i < 8; i++) begin
      push_cmd(16'h0100 + 16'(i));
      if (i == 6) chk("ready_at7", 42'(bus.host_cmd_ready), 42'd1);
    end
    chk("cmd_full", 42'(bus.host_cmd_ready), 42'd0);
    chk("cmd_fifo_head", 42'(bus.usb_read_data), 42'h0100);
    bus.host_cmd_valid = 1'b1;
    bus.host_cmd_data  = 16'h0200;
    read_pulse();
    bus.host_cmd_valid = 1'b0;
    chk("full_pop_head", 42'(bus.usb_read_data), 42'h0101);
    chk("full_pop_ready", 42'(bus.host_cmd_ready), 42'd1);
    chk("other_cmd_keeps_frame", 42'(bus.frame_active), 42'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read", 42'({bus.usb_read_wait, bus.usb_read_data, bus.host_cmd_ready}), {25'd0, 1'b1, 16'h0, 1'b1});
    chk("mid_rst_rx", 42'({bus.rx_valid, bus.rx_index, bus.rx_data}), 42'd0);
    chk("mid_rst_ctl", 42'({bus.rx_last, bus.frame_active, bus.frame_done, bus.usb_write_wait}), 42'd0);
    chk("mid_rst_errs", 42'({bus.overflow_err, bus.underflow_err, bus.proto_err}), 42'd0);
    tick();
    rst_n = 1'b1;
    tick();
    push_cmd(16'hFFFF);
    read_pulse();
    wr(16'h0007);
    wr(16'h0008);
    chk("post_rst_sample", 42'({bus.rx_valid, bus.rx_index, bus.rx_data}), {1'b1, 10'd0, 32'h00080007});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
